// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two master request ports plus the single-port memory side.
// The slave modport is the arbiter's view; the master modport is the masters' and memory's view.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory with fixed read latency RD_LAT (1..7).
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input logic          Clock,
    input logic          Resetn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e        state_q, state_d;
    logic          gnt0, gnt1, mem_we, prio0, rd_done;
    logic          owner_q, op_we_q;
    logic [2:0]    cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          rvalid0_q, rvalid1_q;

`ifdef MEM_ARBITER_RR_EN
    logic last_q;

    // last_q = 1 means master 1 won most recently, so master 0 takes the next tie
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_q <= gnt1;
        end
    end

    assign prio0 = last_q;
`else
    assign prio0 = 1'b1;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign rd_done = (state_q == StWait) && (cnt_q == 3'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt0 || gnt1) state_d = StAccess;
            StAccess: state_d = op_we_q ? StIdle : StWait;
            StWait:   if (cnt_q == 3'd0) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Grants are combinational in IDLE and suppressed while reset is held
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        mem_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                gnt0 = Resetn && bus.m0_req && (prio0 || !bus.m1_req);
                gnt1 = Resetn && bus.m1_req && !gnt0;
            end
            StAccess: mem_we = op_we_q;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            owner_q     <= 1'b0;
            op_we_q     <= 1'b0;
            cnt_q       <= 3'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            rvalid0_q <= rd_done && !owner_q;
            rvalid1_q <= rd_done && owner_q;
            if (gnt0 || gnt1) begin
                owner_q     <= gnt1;
                op_we_q     <= gnt1 ? bus.m1_we    : bus.m0_we;
                mem_addr_q  <= gnt1 ? bus.m1_addr  : bus.m0_addr;
                mem_wdata_q <= gnt1 ? bus.m1_wdata : bus.m0_wdata;
            end
            // Counter holds remaining WAIT cycles after the current one
            if (state_q == StAccess) begin
                cnt_q <= 3'(RD_LAT - 1);
            end else if (state_q == StWait && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (rd_done) begin
                if (owner_q) rdata1_q <= bus.mem_rdata;
                else         rdata0_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take these parameters: AW, 16, address width; DW, 16, data width; RD_LAT, 2, memory read latency in cycles, legal range 1..7.
REQ-002 The block SHALL have these ports, with master index N in {0,1}:
- Clock  in  1  single clock; all state on the rising edge
- Resetn  in  1  reset, asynchronous, active-low
- mN_req  in  1  master N access request
- mN_we  in  1  master N write (1) / read (0)
- mN_addr  in  AW  master N address
- mN_wdata  in  DW  master N write data
- mN_gnt  out  1  master N request accepted (1-cycle pulse)
- mN_rvalid  out  1  master N read data valid (1-cycle pulse)
- mN_rdata  out  DW  master N last read data
- mem_addr  out  AW  address to the single-port memory
- mem_wdata  out  DW  write data to memory
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  read data from memory

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, WAIT.
REQ-004 Arbitration SHALL happen only in IDLE: if any mN_req=1, exactly one mN_gnt is asserted combinationally in that cycle (cycle t), and no gnt is asserted in ACCESS or WAIT.
REQ-005 At the end of cycle t, the winner's addr, wdata and we SHALL be registered onto mem_addr, mem_wdata and an internal op flag, and the state SHALL move to ACCESS.
REQ-006 In ACCESS (cycle t+1), mem_we SHALL equal the latched we; mem_we SHALL be 0 in all other states.
REQ-007 Write: ACCESS SHALL go to IDLE, so the next grant is possible no earlier than cycle t+2.
REQ-008 Read: ACCESS SHALL go to WAIT and load a latency counter; mem_rdata is valid during cycle t+1+RD_LAT.
REQ-009 At the end of cycle t+1+RD_LAT, mem_rdata SHALL be captured into the owner's mN_rdata, and the state SHALL return to IDLE.
REQ-010 The owner's mN_rvalid SHALL be 1 for exactly cycle t+2+RD_LAT, and a new grant may occur in that same cycle.
REQ-011 mN_rdata SHALL hold its value until that master's next read completes; the other master's rdata SHALL be unaffected.
REQ-012 mem_addr and mem_wdata SHALL hold their last values outside ACCESS/WAIT.
REQ-013 A requester SHALL hold req and its fields stable until gnt; fields are sampled only in the gnt cycle; req held while the block is busy is ignored until IDLE, with no queuing.
REQ-014 A single requester in IDLE SHALL always be granted immediately.
REQ-015 Counter width SHALL be 3 bits; RD_LAT=1 SHALL spend exactly one cycle in WAIT with no counter wrap.

Reset
REQ-016 While Resetn=0, the block SHALL force state IDLE, all gnt/rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, all mN_rdata=0, and the last-grant pointer to master 1.
REQ-017 Reset asserted in ACCESS or WAIT SHALL abort the transaction: mem_we drops immediately (asynchronously), and no rvalid is ever issued for it.
REQ-018 After reset release, the first simultaneous-request tie SHALL go to master 0.

Configuration
REQ-019 With macro MEM_ARBITER_RR_EN defined, ties SHALL be round-robin: the master not granted most recently wins, and the pointer updates only on a grant.
REQ-020 Without MEM_ARBITER_RR_EN, arbitration SHALL be fixed priority: master 0 always wins ties, the pointer logic is absent, and master 1 may starve.

Verification
REQ-021 m0 writes addr 0x0010, data 0xBEEF, m1 idle -> m0_gnt in cycle 0; mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF in cycle 1 only; m1 outputs stay 0.
REQ-022 m0 reads 0x0010, RD_LAT=2, memory model returns 0xBEEF -> m0_rvalid=1 in cycle 4 only; m0_rdata=0xBEEF held afterwards; mem_we=0 throughout.
REQ-023 Both masters issue continuous write requests -> with RR_EN, grants go m0,m1,m0,m1 at cycles 0,2,4,6; without RR_EN, m0_gnt every 2 cycles and m1_gnt never.
REQ-024 m1_req rises in cycle 2 of an m0 read (RD_LAT=2) -> m1_gnt not before cycle 4, then exactly in cycle 4, alongside m0_rvalid.
REQ-025 Resetn pulsed low during WAIT of an m1 read -> mem_we=0 at once, no m1_rvalid, m1_rdata=0; next simultaneous request grants m0.
REQ-026 m0 writes 0x0001 at 0x0020, then reads 0x0020 with RD_LAT=1 -> read gnt in cycle 2; m0_rvalid in cycle 5 with rdata=0x0001.
